// File: rtl/adaptive_peak_detector.sv
// Adaptive-threshold peak detector: running mean + decaying envelope.
// Optional re-arm hysteresis: define ADAPTIVE_PEAK_DET_HYST_EN.
module adaptive_peak_detector #(
  parameter int DATA_W       = 16,
  parameter int ADAPT_LOG2   = 4,
  parameter int DECAY_SHIFT  = 4,
  parameter int THR_SHIFT    = 1,
  parameter int CONFIRM_LEN  = 3,
  parameter int MIN_DISTANCE = 8,
  parameter int MIN_THR      = 100,
  parameter int MAX_THR      = 40000,
  parameter int TS_W         = 16,
  parameter int HYST         = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_value,
  output logic [TS_W-1:0]   peak_time,
  output logic [DATA_W-1:0] threshold,
  output logic              armed
);

  localparam int DEPTH  = 1 << ADAPT_LOG2;
  localparam int SUM_W  = DATA_W + ADAPT_LOG2;
  localparam int HOLD_W = $clog2(CONFIRM_LEN + 1);
  localparam int CNT_W  = $clog2(MIN_DISTANCE + 1);

  localparam logic [DATA_W:0] MIN_T = (DATA_W+1)'(MIN_THR);
  localparam logic [DATA_W:0] MAX_T = (DATA_W+1)'(MAX_THR);

`ifdef ADAPTIVE_PEAK_DET_HYST_EN
  localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);
  typedef enum logic [2:0] {
    WARMUP, SEARCH, TRACK, REFRACT, ARM
  } state_t;
`else
  typedef enum logic [1:0] {
    WARMUP, SEARCH, TRACK, REFRACT
  } state_t;
`endif

  state_t state;

  logic [DATA_W-1:0]     buf_q [DEPTH];
  logic [ADAPT_LOG2-1:0] ptr;
  logic [ADAPT_LOG2-1:0] fill;
  logic [SUM_W-1:0]      sum_q;
  logic [DATA_W-1:0]     env_q;
  logic [TS_W-1:0]       ts;
  logic [DATA_W-1:0]     cand;
  logic [TS_W-1:0]       cand_ts;
  logic [HOLD_W-1:0]     hold;
  logic [CNT_W-1:0]      cnt;

  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] mean_nxt;
  logic [DATA_W-1:0] env_dec;
  logic [DATA_W-1:0] env_nxt;
  logic [DATA_W:0]   thr_raw;
  logic [DATA_W-1:0] thr_nxt;

  always_comb begin
    sum_nxt  = sum_q + SUM_W'(data_in) - SUM_W'(buf_q[ptr]);
    mean_nxt = DATA_W'(sum_nxt >> ADAPT_LOG2);
    env_dec  = env_q - (env_q >> DECAY_SHIFT);
    env_nxt  = (data_in >= env_dec) ? data_in : env_dec;
  end

  // Threshold sits between mean and envelope; wide to avoid overflow.
  always_comb begin
    thr_raw = {1'b0, mean_nxt};
    if (env_nxt > mean_nxt)
      thr_raw = {1'b0, mean_nxt}
              + ((DATA_W+1)'(env_nxt - mean_nxt) >> THR_SHIFT);
    thr_nxt = thr_raw[DATA_W-1:0];
    if (thr_raw < MIN_T)
      thr_nxt = MIN_T[DATA_W-1:0];
    else if (thr_raw > MAX_T)
      thr_nxt = MAX_T[DATA_W-1:0];
  end

`ifdef ADAPTIVE_PEAK_DET_HYST_EN
  logic [DATA_W-1:0] thr_low;

  always_comb begin
    thr_low = '0;
    if (threshold > HYST_V)
      thr_low = threshold - HYST_V;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WARMUP;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_time  <= '0;
      threshold  <= MIN_T[DATA_W-1:0];
      armed      <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        buf_q[i] <= '0;
      ptr     <= '0;
      fill    <= '0;
      sum_q   <= '0;
      env_q   <= '0;
      ts      <= '0;
      cand    <= '0;
      cand_ts <= '0;
      hold    <= '0;
      cnt     <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (in_valid) begin
        buf_q[ptr] <= data_in;
        ptr        <= ptr + 1'b1;
        sum_q      <= sum_nxt;
        env_q      <= env_nxt;
        threshold  <= thr_nxt;
        ts         <= ts + 1'b1;

        // Detection compares against the threshold held before this sample.
        unique case (state)
          WARMUP: begin
            if (&fill) begin
              state <= SEARCH;
              armed <= 1'b1;
            end else begin
              fill <= fill + 1'b1;
            end
          end
          SEARCH: begin
            if (data_in > threshold) begin
              state   <= TRACK;
              cand    <= data_in;
              cand_ts <= ts;
              hold    <= '0;
            end
          end
          TRACK: begin
            if (data_in > cand) begin
              cand    <= data_in;
              cand_ts <= ts;
              hold    <= '0;
            end else if (hold == HOLD_W'(CONFIRM_LEN - 1)) begin
              peak_valid <= 1'b1;
              peak_value <= cand;
              peak_time  <= cand_ts;
              hold       <= '0;
              cnt        <= CNT_W'(MIN_DISTANCE);
              state      <= REFRACT;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          REFRACT: begin
            if (cnt <= CNT_W'(1)) begin
              cnt <= '0;
`ifdef ADAPTIVE_PEAK_DET_HYST_EN
              state <= ARM;
              armed <= 1'b0;
`else
              state <= SEARCH;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`ifdef ADAPTIVE_PEAK_DET_HYST_EN
          ARM: begin
            if (data_in <= thr_low) begin
              state <= SEARCH;
              armed <= 1'b1;
            end
          end
`endif
          default: state <= WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adaptive_peak_detector.sv
// Directed self-checking bench for adaptive_peak_detector.
// Covers reset, warm-up, basic peak, refractory, valid gaps, clamp.
module tb_adaptive_peak_detector;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] data_in;
  logic        peak_valid;
  logic [15:0] peak_value;
  logic [15:0] peak_time;
  logic [15:0] threshold;
  logic        armed;

  int checks;
  int errors;
  int n_peaks;
  int last_val;
  int last_time;
  int base;

  adaptive_peak_detector dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .peak_valid (peak_valid),
    .peak_value (peak_value),
    .peak_time  (peak_time),
    .threshold  (threshold),
    .armed      (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (peak_valid) begin
      n_peaks   <= n_peaks + 1;
      last_val  <= int'(peak_value);
      last_time <= int'(peak_time);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic basic_tail();
    push(16'd1000);
    chk("thr_after_1000", 32'(threshold), 32'd625);
    push(16'd3000);
    chk("thr_after_3000", 32'(threshold), 32'd1712);
    push(16'd2000);
    push(16'd1500);
    chk("no_early_pulse", 32'(peak_valid), 32'd0);
    push(16'd1200);
    chk("basic_pulse", 32'(peak_valid), 32'd1);
    chk("basic_value", 32'(peak_value), 32'd3000);
    chk("basic_time", 32'(peak_time), 32'd17);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    n_peaks   = 0;
    last_val  = 0;
    last_time = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    repeat (2) @(negedge clk);
    chk("rst_pv", 32'(peak_valid), 32'd0);
    chk("rst_thr", 32'(threshold), 32'd100);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_pval", 32'(peak_value), 32'd0);
    chk("rst_ptime", 32'(peak_time), 32'd0);
    rst = 1'b0;

    // Warm-up
    repeat (15) push(16'd5000);
    chk("warm_armed15", 32'(armed), 32'd0);
    push(16'd5000);
    chk("warm_armed16", 32'(armed), 32'd1);
    chk("warm_thr", 32'(threshold), 32'd5000);
    idle(1);
    chk("warm_no_peak", 32'(n_peaks), 32'd0);

    // Basic peak followed by refractory
    do_reset();
    repeat (16) push(16'd200);
    chk("base_thr", 32'(threshold), 32'd200);
    chk("base_armed", 32'(armed), 32'd1);
    basic_tail();
    idle(1);
    chk("basic_count", 32'(n_peaks), 32'd1);
    chk("pulse_clear", 32'(peak_valid), 32'd0);
    push(16'd200);
    push(16'd5000);
    repeat (8) push(16'd200);
    idle(1);
    chk("refr_blocked", 32'(n_peaks), 32'd1);
    push(16'd6000);
    repeat (3) push(16'd200);
    idle(1);
    chk("refr_count", 32'(n_peaks), 32'd2);
    chk("refr_value", 32'(last_val), 32'd6000);
    chk("refr_time", 32'(last_time), 32'd31);

    // Reset in the middle of TRACK
    do_reset();
    repeat (16) push(16'd200);
    push(16'd1000);
    push(16'd3000);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_pv", 32'(peak_valid), 32'd0);
    chk("mid_rst_thr", 32'(threshold), 32'd100);
    chk("mid_rst_armed", 32'(armed), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(16'd2000);
    push(16'd1500);
    push(16'd1200);
    push(16'd1200);
    idle(2);
    chk("mid_rst_nopulse", 32'(n_peaks), 32'd2);

    // Same basic stimulus with gaps of 1-3 idle cycles
    do_reset();
    base = n_peaks;
    for (int i = 0; i < 16; i++) begin
      push(16'd200);
      idle(1 + (i % 3));
    end
    push(16'd1000);
    idle(2);
    push(16'd3000);
    idle(3);
    push(16'd2000);
    idle(1);
    push(16'd1500);
    idle(2);
    push(16'd1200);
    idle(1);
    chk("gap_count", 32'(n_peaks - base), 32'd1);
    chk("gap_value", 32'(last_val), 32'd3000);
    chk("gap_time", 32'(last_time), 32'd17);

    // Threshold clamp with saturated input
    do_reset();
    base = n_peaks;
    repeat (20) push(16'd60000);
    idle(1);
    chk("clamp_thr", 32'(threshold), 32'd40000);
    chk("clamp_first", 32'(n_peaks - base), 32'd1);
    chk("clamp_value", 32'(last_val), 32'd60000);
    chk("clamp_time", 32'(last_time), 32'd16);
    repeat (44) push(16'd60000);
    chk("clamp_thr_end", 32'(threshold), 32'd40000);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
